tt_um_emern_load_scheduler: RTL and testbench

Schedules when SPI command traffic may update the rasterizer's register file. It opens a load window only during vertical blanking and raises the host interrupt when the window opens. It defers or applies register commits so the pixel core never sees a half-written polygon mid-frame. It sits between the VGA timing generator and the SPI frontend, driving the frontend's load enable and the interrupt pin.

---
 rtl/tt_um_emern_load_scheduler.sv | 129 ++++++++++++
 tb/tb_tt_um_emern_load_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_emern_load_scheduler.sv
// Purpose: gates SPI register loads to vertical blanking, raises host IRQ on window open, defers commits outside the window.
// Latency: all outputs registered; 1 cycle from event to output, cs_in sees +2 cycles of synchronizer.
// Backpressure: none; en_load withdrawal is the only throttle on the SPI frontend.
//
// Ports:
//   clk, rst_n                 : 25 MHz pixel clock, synchronous active-low reset
//   row_counter, col_counter   : VGA raster position from the timing generator
//   cs_in                      : raw SPI chip select (active-low, asynchronous)
//   commit_req                 : frontend says a full command is staged
//   overrun_clr                : clears the sticky overrun flag
//   en_load, commit_strobe     : frontend load enable / staged->active transfer pulse
//   int_out, xfer_abort        : host interrupt / transfer cut at window close
//   overrun, frame_count       : sticky abort flag / count of windows opened
module tt_um_emern_load_scheduler #(
  parameter int V_VISIBLE      = 480,
  parameter int V_TOTAL        = 525,
  parameter int GUARD_LINES    = 2,
  parameter int INT_MAX_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] row_counter,
  input  logic [9:0] col_counter,
  input  logic       cs_in,
  input  logic       commit_req,
  input  logic       overrun_clr,
  output logic       en_load,
  output logic       commit_strobe,
  output logic       int_out,
  output logic       xfer_abort,
  output logic       overrun,
  output logic [7:0] frame_count
);

  localparam int         INT_W     = $clog2(INT_MAX_CYCLES + 1);
  localparam logic [9:0] ROW_OPEN  = 10'(V_VISIBLE);
  localparam logic [9:0] ROW_CLOSE = 10'(V_TOTAL - GUARD_LINES);
  localparam logic [INT_W-1:0] INT_LAST = INT_W'(INT_MAX_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, OPEN, BUSY, ABORT, WAIT_CS} state_t;

  state_t           state, state_nxt;
  logic             cs_meta, cs_s, cs_d;
  logic             pending;
  logic [INT_W-1:0] int_cnt;

  logic cs_fall, open_evt, close_cond, in_window, nxt_in_window, opening;

  assign cs_fall       = cs_d & ~cs_s;
  assign open_evt      = (row_counter == ROW_OPEN) && (col_counter == 10'd0);
  // A row below the window start while open means the close row was skipped;
  // treat it exactly like the close event.
  assign close_cond    = ((row_counter == ROW_CLOSE) && (col_counter == 10'd0)) ||
                         (row_counter < ROW_OPEN);
  assign in_window     = (state == OPEN) || (state == BUSY);
  assign nxt_in_window = (state_nxt == OPEN) || (state_nxt == BUSY);
  assign opening       = (state == IDLE) && open_evt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (open_evt) state_nxt = OPEN;
      OPEN: begin
        if (close_cond)   state_nxt = cs_s ? IDLE : ABORT;
        else if (cs_fall) state_nxt = BUSY;
      end
      BUSY: begin
        if (close_cond)   state_nxt = cs_s ? IDLE : ABORT;
        else if (cs_s)    state_nxt = OPEN;
      end
      ABORT:   state_nxt = WAIT_CS;
      // Hold off until the host releases CS so the tail of the cut
      // transfer is not mistaken for a fresh one.
      WAIT_CS: if (cs_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cs_meta       <= 1'b1;
      cs_s          <= 1'b1;
      cs_d          <= 1'b1;
      pending       <= 1'b0;
      int_cnt       <= '0;
      en_load       <= 1'b0;
      commit_strobe <= 1'b0;
      int_out       <= 1'b0;
      xfer_abort    <= 1'b0;
      overrun       <= 1'b0;
      frame_count   <= 8'd0;
    end else begin
      cs_meta <= cs_in;
      cs_s    <= cs_meta;
      cs_d    <= cs_s;
      state   <= state_nxt;

      en_load    <= nxt_in_window;
      xfer_abort <= (state_nxt == ABORT);

      // Set beats clear when both land on the same cycle.
      if (state_nxt == ABORT) overrun <= 1'b1;
      else if (overrun_clr)   overrun <= 1'b0;

      // Deferred requests collapse into the single pending bit and are
      // released on the first cycle of the next window.
      if (opening) begin
        commit_strobe <= pending | commit_req;
        pending       <= 1'b0;
      end else begin
        commit_strobe <= in_window & commit_req;
        if (!in_window && commit_req) pending <= 1'b1;
      end

      frame_count <= frame_count + 8'(opening);

      if (opening) begin
        int_out <= 1'b1;
        int_cnt <= '0;
      end else if (int_out) begin
        int_cnt <= int_cnt + INT_W'(1);
        if (!nxt_in_window || (in_window && cs_fall) || (int_cnt == INT_LAST))
          int_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_um_emern_load_scheduler.sv
module tb_tt_um_emern_load_scheduler;

  localparam int COLS    = 4;
  localparam int INT_MAX = 1023;
  localparam int M_ACT = 0, M_WIN = 1, M_XFER = 2, M_ABORT = 3, M_DRAIN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] row_counter = '0;
  logic [9:0] col_counter = '0;
  logic       cs_in = 1'b1;
  logic       commit_req = 1'b0;
  logic       overrun_clr = 1'b0;
  logic       en_load, commit_strobe, int_out, xfer_abort, overrun;
  logic [7:0] frame_count;

  tt_um_emern_load_scheduler dut (
    .clk(clk), .rst_n(rst_n), .row_counter(row_counter), .col_counter(col_counter),
    .cs_in(cs_in), .commit_req(commit_req), .overrun_clr(overrun_clr),
    .en_load(en_load), .commit_strobe(commit_strobe), .int_out(int_out),
    .xfer_abort(xfer_abort), .overrun(overrun), .frame_count(frame_count)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int         cyc = 0;
  int         m_mode = M_ACT;
  logic       h[3] = '{1'b1, 1'b1, 1'b1};  // cs_in history, newest first
  logic       m_pend = 0, m_int_live = 0, m_commit = 0, m_abort = 0, m_ovr = 0;
  int         m_raise = 0;
  logic [7:0] m_frame = 0;

  int n_commit = 0, n_abort = 0;

  // Per-frame stimulus knobs
  int  commit_rows[$];
  int  cs_lo_row = -1, cs_hi_row = -1, clr_row = -1;
  bit  rnd = 0;

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %0d expected %0d (cycle %0d row %0d)", tag, got, exp, cyc, row_counter);
    end
  endtask

  task automatic model_step();
    logic cs_s, fall, open, close, win;
    if (!rst_n) begin
      m_mode = M_ACT; m_pend = 0; m_int_live = 0; m_commit = 0; m_abort = 0;
      m_ovr = 0; m_frame = 0; h = '{1'b1, 1'b1, 1'b1};
      return;
    end
    cs_s  = h[1];
    fall  = h[2] && !h[1];
    open  = (row_counter == 10'd480) && (col_counter == 10'd0);
    close = ((row_counter == 10'd523) && (col_counter == 10'd0)) || (row_counter < 10'd480);
    win   = (m_mode == M_WIN) || (m_mode == M_XFER);
    m_commit = 0; m_abort = 0;
    if (m_mode == M_ACT) begin
      if (open) begin
        m_mode = M_WIN; m_frame++; m_int_live = 1; m_raise = cyc;
        m_commit = m_pend || commit_req; m_pend = 0;
      end else if (commit_req) m_pend = 1;
    end else if (win) begin
      m_commit = commit_req;
      if (fall) m_int_live = 0;
      if (close) begin
        if (cs_s) m_mode = M_ACT;
        else begin m_mode = M_ABORT; m_abort = 1; end
      end else if (m_mode == M_WIN && fall) m_mode = M_XFER;
      else if (m_mode == M_XFER && cs_s) m_mode = M_WIN;
    end else begin
      if (commit_req) m_pend = 1;
      if (m_mode == M_ABORT) m_mode = M_DRAIN;
      else if (cs_s) m_mode = M_ACT;
    end
    if (m_abort) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    if (!(m_mode == M_WIN || m_mode == M_XFER)) m_int_live = 0;
    h[2] = h[1]; h[1] = h[0]; h[0] = cs_in;
  endtask

  task automatic tick();
    logic e_en, e_int;
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    e_en  = (m_mode == M_WIN) || (m_mode == M_XFER);
    e_int = m_int_live && ((cyc - m_raise) < INT_MAX);
    chk("en_load", 10'(en_load), 10'(e_en));
    chk("int_out", 10'(int_out), 10'(e_int));
    chk("commit_strobe", 10'(commit_strobe), 10'(m_commit));
    chk("xfer_abort", 10'(xfer_abort), 10'(m_abort));
    chk("overrun", 10'(overrun), 10'(m_ovr));
    chk("frame_count", 10'(frame_count), 10'(m_frame));
    if (commit_strobe) n_commit++;
    if (xfer_abort) n_abort++;
  endtask

  task automatic run_rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++) begin
      for (int c = 0; c < COLS; c++) begin
        row_counter = 10'(r);
        col_counter = 10'(c);
        commit_req  = 1'b0;
        overrun_clr = 1'b0;
        if (c == 0) begin
          foreach (commit_rows[i]) if (commit_rows[i] == r) commit_req = 1'b1;
          if (r == cs_lo_row) cs_in = 1'b0;
          if (r == cs_hi_row) cs_in = 1'b1;
          if (r == clr_row)   overrun_clr = 1'b1;
        end
        if (rnd) begin
          if ($urandom_range(39) == 0) cs_in = ~cs_in;
          if ($urandom_range(29) == 0) commit_req = 1'b1;
          if ($urandom_range(49) == 0) overrun_clr = 1'b1;
        end
        tick();
      end
    end
    commit_req = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic clear_knobs();
    commit_rows.delete();
    cs_lo_row = -1; cs_hi_row = -1; clr_row = -1; rnd = 0;
  endtask

  task automatic fast_frame();
    row_counter = 10'd479; col_counter = 10'd5; tick();
    row_counter = 10'd480; col_counter = 10'd0; tick();
    row_counter = 10'd500; col_counter = 10'd1; tick();
    row_counter = 10'd523; col_counter = 10'd0; tick();
    row_counter = 10'd524; col_counter = 10'd0; tick();
  endtask

  initial begin
    logic [7:0] fc_before;

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_en_load", 10'(en_load), 10'd0);
    chk("reset_frame_count", 10'(frame_count), 10'd0);
    rst_n = 1'b1;

    // Frame 1: two deferred commits collapse into one at window open
    clear_knobs();
    commit_rows.push_back(100);
    commit_rows.push_back(200);
    n_commit = 0;
    run_rows(0, 479);
    chk("no_commit_before_open", 10'(n_commit), 10'd0);
    run_rows(480, 480);
    chk("open_en_load", 10'(en_load), 10'd1);
    chk("open_frame_count", 10'(frame_count), 10'd1);
    chk("deferred_commit_once", 10'(n_commit), 10'd1);
    n_abort = 0;
    run_rows(481, 524);
    chk("clean_close_en_load", 10'(en_load), 10'd0);
    chk("clean_close_no_abort", 10'(n_abort), 10'd0);

    // Frame 2: short transfer, in-window commit, commit at the close event
    clear_knobs();
    cs_lo_row = 490; cs_hi_row = 495;
    commit_rows.push_back(485);
    commit_rows.push_back(523);
    run_rows(0, 524);

    // Frame 3: CS held across the close row -> abort and drain
    clear_knobs();
    cs_lo_row = 520; cs_hi_row = 524;
    n_abort = 0;
    run_rows(0, 524);
    chk("abort_once", 10'(n_abort), 10'd1);
    chk("abort_overrun", 10'(overrun), 10'd1);

    // Frame 4: clear overrun, then clear coincident with a new abort
    clear_knobs();
    clr_row = 10;
    run_rows(0, 30);
    chk("overrun_cleared", 10'(overrun), 10'd0);
    clr_row = 523; cs_lo_row = 521; cs_hi_row = 524;
    run_rows(31, 524);
    chk("set_beats_clear", 10'(overrun), 10'd1);

    // Interrupt timeout: dwell inside the window longer than the limit
    clear_knobs();
    run_rows(0, 481);
    row_counter = 10'd481; col_counter = 10'd1;
    repeat (1100) tick();
    chk("int_timeout", 10'(int_out), 10'd0);
    run_rows(482, 524);

    // Skipped close row: row jumps from inside the window back to 0
    clear_knobs();
    run_rows(470, 490);
    run_rows(0, 3);
    chk("skip_close_en_load", 10'(en_load), 10'd0);

    // Randomized frames
    clear_knobs();
    rnd = 1;
    repeat (4) run_rows(0, 524);
    clear_knobs();
    cs_in = 1'b1;
    run_rows(0, 524);

    // Frame counter wrap
    fc_before = frame_count;
    for (int i = 0; i < 256; i++) fast_frame();
    chk("frame_count_wrap", 10'(frame_count), 10'(fc_before));

    // Reset mid-window, release inside vblank
    clear_knobs();
    run_rows(0, 499);
    rst_n = 1'b0;
    run_rows(500, 504);
    chk("midwin_reset_en_load", 10'(en_load), 10'd0);
    chk("midwin_reset_int", 10'(int_out), 10'd0);
    rst_n = 1'b1;
    run_rows(505, 524);
    run_rows(0, 479);
    chk("no_partial_window", 10'(en_load), 10'd0);
    run_rows(480, 482);
    chk("next_window_opens", 10'(en_load), 10'd1);
    chk("next_window_count", 10'(frame_count), 10'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
